gfx_rom_arbiter: RTL and testbench

//  Shares the single graphics-ROM/SDRAM read port between the tile-layer, sprite and text fetchers.

---
 rtl/gfx_rom_arbiter_pkg.sv | 9 +
 rtl/gfx_rom_arbiter_rr_pick.sv | 25 ++
 rtl/gfx_rom_arbiter.sv | 84 ++++++++
 tb/tb_gfx_rom_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/gfx_rom_arbiter_pkg.sv
// gfx_rom_arbiter_pkg: shared state encoding, requester indices and timeout default
package gfx_rom_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam int REQ_BG  = 0;
  localparam int REQ_FG  = 1;
  localparam int REQ_SPR = 2;
  localparam int REQ_TXT = 3;
  localparam int TMO_DEF = 255;
endpackage

// File: rtl/gfx_rom_arbiter_rr_pick.sv
// gfx_rom_arbiter_rr_pick: round-robin winner select with an optional forced (priority) requester
module gfx_rom_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  input  logic            force_en,
  input  logic [IW-1:0]   force_idx,
  output logic [IW-1:0]   winner,
  output logic            any
);
  logic [IW-1:0] idx;
  // scan downward so the last hit is the first set request above rr_ptr; a requesting forced index overrides
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(rr_ptr) + k) % NREQ);
      if (req[idx]) winner = idx;
    end
    if (force_en && req[force_idx]) winner = force_idx;
  end
  assign any = |req;
endmodule

// File: rtl/gfx_rom_arbiter.sv
// gfx_rom_arbiter: shares the graphics ROM read port between fetchers, sprite owns it during hblank
module gfx_rom_arbiter
  import gfx_rom_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = 24,
  parameter int DW      = 32,
  parameter int SPR_IDX = REQ_SPR,
  parameter int TMO     = TMO_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hbl,
  input  logic             vbl,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]  rd_valid,
  output logic [DW-1:0]    rd_data,
  output logic             busy,
  output logic             rom_req,
  output logic [AW-1:0]    rom_addr,
  input  logic             rom_ack,
  input  logic [DW-1:0]    rom_data,
  output logic             err_timeout
);
  localparam int IW = $clog2(NREQ);
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, owner, winner;
  logic any, timeout, unused_vbl;
  logic [7:0] tmo_cnt;
  assign unused_vbl = vbl;
  assign timeout = (tmo_cnt == 8'(TMO));
  gfx_rom_arbiter_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req(req),
    .rr_ptr(rr_ptr),
    .force_en(hbl),
    .force_idx(IW'(SPR_IDX)),
    .winner(winner),
    .any(any)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next state: grant from IDLE, finish on ack or timeout, DONE lasts one cycle
  always_comb
    state_nx = state == IDLE ? (any ? BUSY : IDLE) :
               state == BUSY ? ((rom_ack || timeout) ? DONE : BUSY) : IDLE;
  // status output
  always_comb busy = (state != IDLE);
  // grant latches, ROM request, timeout counter and response pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rom_req <= 1'b0;
      rom_addr <= '0;
      rd_valid <= '0;
      rd_data <= '0;
      err_timeout <= 1'b0;
      rr_ptr <= IW'(NREQ - 1);
      owner <= '0;
      tmo_cnt <= '0;
    end else begin
      rd_valid <= '0;
      if (state == IDLE && any) begin
        owner <= winner;
        rr_ptr <= winner;
        rom_addr <= addr[int'(winner)*AW +: AW];
        rom_req <= 1'b1;
        tmo_cnt <= '0;
      end
      if (state == BUSY) begin
        if (rom_ack) begin
          rd_data <= rom_data;
          rd_valid <= NREQ'(1) << owner;
          rom_req <= 1'b0;
        end else if (timeout) begin
          rd_data <= '0;
          rd_valid <= NREQ'(1) << owner;
          rom_req <= 1'b0;
          err_timeout <= 1'b1;
        end else tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// tb_gfx_rom_arbiter: randomized transaction-level check of the ROM arbiter against a grant model
module tb_gfx_rom_arbiter;
  logic clk = 1'b0, reset = 1'b1, hbl = 1'b0, vbl = 1'b0, rom_ack = 1'b0;
  logic [3:0] req = '0;
  logic [95:0] addr = '0;
  logic [31:0] rom_data = '0, rd_data;
  logic [3:0] rd_valid;
  logic busy, rom_req, err_timeout;
  logic [23:0] rom_addr;
  int n_tests = 0, n_fail = 0;
  int ptr = 3;
  bit exp_err = 1'b0;

  gfx_rom_arbiter dut (
    .clk(clk), .reset(reset), .hbl(hbl), .vbl(vbl), .req(req), .addr(addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .rom_req(rom_req),
    .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input logic h);
    if (h && r[2]) return 2;
    for (int k = 1; k <= 4; k++)
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic do_txn(input logic [3:0] r, input logic h, input int ack_at, input bit jitter,
                        input logic [23:0] a0, input bit fixed_a0);
    int w;
    logic [31:0] d;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_valid", rd_valid, 0);
    req = r;
    hbl = h;
    vbl = 1'($urandom);
    rom_ack = 1'b0;
    for (int s = 0; s < 4; s++) addr[s*24 +: 24] = 24'($urandom);
    if (fixed_a0) addr[23:0] = a0;
    w = pick(r, h);
    ptr = w;
    @(posedge clk);
    #1;
    chk("grant_rom_req", rom_req, 1);
    chk("grant_rom_addr", rom_addr, addr[w*24 +: 24]);
    chk("grant_busy", busy, 1);
    for (int i = 0; i <= 255; i++) begin
      @(negedge clk);
      if (jitter) req = 4'($urandom);
      rom_ack = (i == ack_at);
      d = $urandom;
      rom_data = d;
      @(posedge clk);
      #1;
      if (i == ack_at || i == 255) begin
        if (i != ack_at) exp_err = 1'b1;
        chk("rd_valid", rd_valid, 32'(4'b0001 << w));
        chk("rd_data", rd_data, i == ack_at ? d : 32'd0);
        chk("rom_req_drop", rom_req, 0);
        chk("done_busy", busy, 1);
        chk("err_timeout", err_timeout, 32'(exp_err));
        break;
      end else begin
        chk("busy_rom_req", rom_req, 1);
        chk("busy_no_valid", rd_valid, 0);
      end
    end
    @(negedge clk);
    rom_ack = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_rom_req", rom_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_err", err_timeout, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // single requester, ack two cycles after rom_req
    do_txn(4'b0001, 1'b0, 1, 1'b0, 24'h000100, 1'b1);
    req = '0;
    @(posedge clk);
    #1;
    chk("basic_busy_low", busy, 0);
    // all requesting, round-robin order
    for (int n = 0; n < 5; n++) do_txn(4'b1111, 1'b0, 0, 1'b0, 24'h0, 1'b0);
    // hblank: sprite absent, then sprite absolute priority
    do_txn(4'b0100, 1'b0, 0, 1'b0, 24'h0, 1'b0);
    do_txn(4'b1011, 1'b1, 0, 1'b0, 24'h0, 1'b0);
    for (int n = 0; n < 3; n++) do_txn(4'b1111, 1'b1, 1, 1'b0, 24'h0, 1'b0);
    // timeout, then ack coincident with the timeout compare
    do_txn(4'b0010, 1'b0, 1000, 1'b0, 24'h0, 1'b0);
    do_txn(4'b1000, 1'b0, 255, 1'b0, 24'h0, 1'b0);
    // ack while idle is ignored
    req = '0;
    rom_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_valid", rd_valid, 0);
    chk("idle_ack_rom_req", rom_req, 0);
    @(negedge clk);
    rom_ack = 1'b0;
    chk("err_sticky", err_timeout, 1);
    // reset mid-transaction
    req = 4'b0001;
    hbl = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_rom_req", rom_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", rd_valid, 0);
    chk("mid_rst_err", err_timeout, 0);
    ptr = 3;
    exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    do_txn(4'b0011, 1'b0, 0, 1'b0, 24'h0, 1'b0);
    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [3:0] r;
      r = 4'($urandom_range(1, 15));
      do_txn(r, 1'($urandom), int'($urandom_range(0, 5)), 1'($urandom), 24'h0, 1'b0);
    end
    req = '0;
    repeat (3) @(negedge clk);
    chk("end_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
